// File: rtl/pc_sequencer_pkg.sv
// Shared RISC constants: PC source select codes and trap/reset vectors.
// Used by both the PC sequencer and the PC register.
package pc_sequencer_pkg;

    // PC source select codes driven on pcsel
    typedef enum logic [2:0] {
        PCSEL_INC    = 3'd0,
        PCSEL_BRANCH = 3'd1,
        PCSEL_JUMP   = 3'd2,
        PCSEL_ILLOP  = 3'd3,
        PCSEL_XADR   = 3'd4,
        PCSEL_HOLD   = 3'd5
    } pcsel_t;

    // Fixed vectors loaded into the PC on reset, illegal opcode and interrupt
    localparam logic [31:0] ADDR_RESET = 32'h8000_0000;
    localparam logic [31:0] ADDR_ILLOP = 32'h8000_0004;
    localparam logic [31:0] ADDR_XADR  = 32'h8000_0008;

    // Width of the per-instruction cycle counter and the multi input
    localparam int CNT_W = 5;

endpackage

// File: rtl/pc_sequencer_irq_latch.sv
// Interrupt pending flag: set by a request, cleared by the acknowledge.
// Clear has priority, so a still-held request must be seen again to re-pend.
module irq_latch (
    input  logic clock,
    input  logic reset_n,
    input  logic set_req,
    input  logic clear_req,
    output logic pending
);

    // Pending flag register with clear-over-set priority
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            pending <= 1'b0;
        end else if (clear_req) begin
            pending <= 1'b0;
        end else if (set_req) begin
            pending <= 1'b1;
        end
    end

endmodule

// File: rtl/pc_sequencer.sv
// PC sequencer: steps multi-cycle instructions, selects the next PC source
// and takes illegal-opcode traps and user-mode interrupts at retire.
module pc_sequencer
    import pc_sequencer_pkg::*;
(
    input  logic             clock,
    input  logic             reset_n,
    input  logic [CNT_W-1:0] multi,
    input  logic             illop,
    input  logic             jump,
    input  logic             branch_taken,
    input  logic             irq_req,
    input  logic             supervisor,
    output logic [2:0]       pcsel,
    output logic             stall,
    output logic             xp_save,
    output logic             irq_ack,
    output logic [CNT_W-1:0] cycle_cnt
);

    // Sequencer states are private to this block
    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_MULTI = 1'b1
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [CNT_W-1:0] cnt_next;
    logic             retire;
    logic             irq_pending;
    pcsel_t           pcsel_sel;

    irq_latch u_irq_latch (
        .clock     (clock),
        .reset_n   (reset_n),
        .set_req   (irq_req),
        .clear_req (irq_ack),
        .pending   (irq_pending)
    );

    // State and cycle counter registers
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state     <= ST_RUN;
            cycle_cnt <= '0;
        end else begin
            state     <= state_next;
            cycle_cnt <= cnt_next;
        end
    end

    // Next state, counter update and PC source selection
    always_comb begin
        state_next = state;
        cnt_next   = cycle_cnt;
        pcsel_sel  = PCSEL_INC;
        stall      = 1'b0;
        xp_save    = 1'b0;
        irq_ack    = 1'b0;
        retire     = 1'b0;

        case (state)
            ST_RUN: begin
                if (illop) begin
                    pcsel_sel = PCSEL_ILLOP;
                    xp_save   = 1'b1;
                    cnt_next  = '0;
                end else if (multi != '0) begin
                    pcsel_sel  = PCSEL_HOLD;
                    stall      = 1'b1;
                    cnt_next   = {{(CNT_W-1){1'b0}}, 1'b1};
                    state_next = ST_MULTI;
                end else begin
                    retire = 1'b1;
                end
            end
            ST_MULTI: begin
                // A counter already past a shrunken multi retires at once
                if (cycle_cnt < multi) begin
                    pcsel_sel = PCSEL_HOLD;
                    stall     = 1'b1;
                    cnt_next  = cycle_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
                end else begin
                    retire = 1'b1;
                end
            end
            default: begin
                state_next = ST_RUN;
                cnt_next   = '0;
            end
        endcase

        if (retire) begin
            cnt_next   = '0;
            state_next = ST_RUN;
            if (irq_pending && !supervisor) begin
                pcsel_sel = PCSEL_XADR;
                xp_save   = 1'b1;
                irq_ack   = 1'b1;
            end else if (jump) begin
                pcsel_sel = PCSEL_JUMP;
            end else if (branch_taken) begin
                pcsel_sel = PCSEL_BRANCH;
            end else begin
                pcsel_sel = PCSEL_INC;
            end
        end

        // Outputs are forced quiet while reset is held, regardless of clock
        if (!reset_n) begin
            pcsel_sel = PCSEL_INC;
            stall     = 1'b0;
            xp_save   = 1'b0;
            irq_ack   = 1'b0;
        end
    end

    assign pcsel = pcsel_sel;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed self-checking bench for the PC sequencer.
module tb_pc_sequencer;

    logic       clock;
    logic       reset_n;
    logic [4:0] multi;
    logic       illop;
    logic       jump;
    logic       branch_taken;
    logic       irq_req;
    logic       supervisor;
    logic [2:0] pcsel;
    logic       stall;
    logic       xp_save;
    logic       irq_ack;
    logic [4:0] cycle_cnt;

    int check_cnt;
    int pass_cnt;

    pc_sequencer dut (
        .clock        (clock),
        .reset_n      (reset_n),
        .multi        (multi),
        .illop        (illop),
        .jump         (jump),
        .branch_taken (branch_taken),
        .irq_req      (irq_req),
        .supervisor   (supervisor),
        .pcsel        (pcsel),
        .stall        (stall),
        .xp_save      (xp_save),
        .irq_ack      (irq_ack),
        .cycle_cnt    (cycle_cnt)
    );

    // Free-running clock, rising edges at 5, 15, 25, ...
    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Drive one cycle's inputs on the falling edge, settle before checking
    task automatic apply_stimulus(input logic [4:0] m, input logic il, input logic jp,
                                  input logic br, input logic irq, input logic sup);
        @(negedge clock);
        multi        = m;
        illop        = il;
        jump         = jp;
        branch_taken = br;
        irq_req      = irq;
        supervisor   = sup;
        #1;
    endtask

    // Single compare with failure count and report
    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        check_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    endtask

    // Compare every output of the current cycle
    task automatic check_output(input string tag, input logic [2:0] e_pcsel, input logic e_stall,
                                input logic e_xp, input logic e_ack, input logic [4:0] e_cnt);
        check({tag, ".pcsel"}, {5'd0, pcsel}, {5'd0, e_pcsel});
        check({tag, ".stall"}, {7'd0, stall}, {7'd0, e_stall});
        check({tag, ".xp_save"}, {7'd0, xp_save}, {7'd0, e_xp});
        check({tag, ".irq_ack"}, {7'd0, irq_ack}, {7'd0, e_ack});
        check({tag, ".cycle_cnt"}, {3'd0, cycle_cnt}, {3'd0, e_cnt});
    endtask

    task automatic check_pending(input string tag, input logic e_pend);
        check({tag, ".irq_pending"}, {7'd0, dut.irq_pending}, {7'd0, e_pend});
    endtask

    // Directed sequence
    initial begin
        check_cnt = 0;
        pass_cnt  = 0;

        // Reset held with illop asserted: outputs must still be zero
        reset_n      = 1'b0;
        multi        = 5'd3;
        illop        = 1'b1;
        jump         = 1'b1;
        branch_taken = 1'b1;
        irq_req      = 1'b0;
        supervisor   = 1'b0;
        #2;
        check_output("reset", 3'd0, 1'b0, 1'b0, 1'b0, 5'd0);
        check_pending("reset", 1'b0);
        multi        = 5'd0;
        illop        = 1'b0;
        jump         = 1'b0;
        branch_taken = 1'b0;
        @(negedge clock);
        reset_n = 1'b1;

        // Plain INC for four cycles
        for (int i = 0; i < 4; i++) begin
            apply_stimulus(5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
            check_output("inc", 3'd0, 1'b0, 1'b0, 1'b0, 5'd0);
        end

        // Multi-cycle jump, multi=3
        apply_stimulus(5'd3, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        check_output("mc.c0", 3'd5, 1'b1, 1'b0, 1'b0, 5'd0);
        apply_stimulus(5'd3, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        check_output("mc.c1", 3'd5, 1'b1, 1'b0, 1'b0, 5'd1);
        apply_stimulus(5'd3, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        check_output("mc.c2", 3'd5, 1'b1, 1'b0, 1'b0, 5'd2);
        apply_stimulus(5'd3, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        check_output("mc.ret", 3'd2, 1'b0, 1'b0, 1'b0, 5'd3);
        apply_stimulus(5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        check_output("mc.run", 3'd0, 1'b0, 1'b0, 1'b0, 5'd0);

        // Interrupt pulse during a multi=2 instruction
        apply_stimulus(5'd2, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        check_output("irqm.c0", 3'd5, 1'b1, 1'b0, 1'b0, 5'd0);
        apply_stimulus(5'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        check_output("irqm.c1", 3'd5, 1'b1, 1'b0, 1'b0, 5'd1);
        check_pending("irqm.c1", 1'b1);
        apply_stimulus(5'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        check_output("irqm.ret", 3'd4, 1'b0, 1'b1, 1'b1, 5'd2);
        apply_stimulus(5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        check_output("irqm.after", 3'd0, 1'b0, 1'b0, 1'b0, 5'd0);
        check_pending("irqm.after", 1'b0);

        // Supervisor masking with the request held
        for (int i = 0; i < 3; i++) begin
            apply_stimulus(5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
            check_output("sup.mask", 3'd0, 1'b0, 1'b0, 1'b0, 5'd0);
        end
        apply_stimulus(5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        check_output("sup.take", 3'd4, 1'b0, 1'b1, 1'b1, 5'd0);
        apply_stimulus(5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        check_output("sup.after", 3'd0, 1'b0, 1'b0, 1'b0, 5'd0);
        check_pending("sup.after", 1'b0);

        // Priority: ILLOP beats everything, then XADR beats JUMP, JUMP beats BRANCH
        apply_stimulus(5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        check_output("prio.pend", 3'd0, 1'b0, 1'b0, 1'b0, 5'd0);
        apply_stimulus(5'd4, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        check_output("prio.illop", 3'd3, 1'b0, 1'b1, 1'b0, 5'd0);
        check_pending("prio.illop", 1'b1);
        apply_stimulus(5'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        check_output("prio.xadr", 3'd4, 1'b0, 1'b1, 1'b1, 5'd0);
        apply_stimulus(5'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        check_output("prio.jump", 3'd2, 1'b0, 1'b0, 1'b0, 5'd0);
        apply_stimulus(5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        check_output("prio.branch", 3'd1, 1'b0, 1'b0, 1'b0, 5'd0);

        // multi shrinks below the counter mid-instruction
        apply_stimulus(5'd4, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        check_output("shrink.c0", 3'd5, 1'b1, 1'b0, 1'b0, 5'd0);
        apply_stimulus(5'd4, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        check_output("shrink.c1", 3'd5, 1'b1, 1'b0, 1'b0, 5'd1);
        apply_stimulus(5'd1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        check_output("shrink.ret", 3'd1, 1'b0, 1'b0, 1'b0, 5'd2);
        apply_stimulus(5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        check_output("shrink.run", 3'd0, 1'b0, 1'b0, 1'b0, 5'd0);

        // multi=31 reaches the counter ceiling without wrapping
        for (int i = 0; i < 31; i++) begin
            apply_stimulus(5'd31, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
            check_output("max.stall", 3'd5, 1'b1, 1'b0, 1'b0, 5'(i));
        end
        apply_stimulus(5'd31, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        check_output("max.ret", 3'd0, 1'b0, 1'b0, 1'b0, 5'd31);
        apply_stimulus(5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        check_output("max.run", 3'd0, 1'b0, 1'b0, 1'b0, 5'd0);

        // Asynchronous reset in the middle of a multi=5 instruction
        apply_stimulus(5'd5, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        check_output("ares.c0", 3'd5, 1'b1, 1'b0, 1'b0, 5'd0);
        apply_stimulus(5'd5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        check_output("ares.c1", 3'd5, 1'b1, 1'b0, 1'b0, 5'd1);
        apply_stimulus(5'd5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        check_output("ares.c2", 3'd5, 1'b1, 1'b0, 1'b0, 5'd2);
        #1;
        reset_n = 1'b0;
        #1;
        check_output("ares.held", 3'd0, 1'b0, 1'b0, 1'b0, 5'd0);
        check_pending("ares.held", 1'b0);
        multi = 5'd0;
        @(negedge clock);
        reset_n = 1'b1;
        apply_stimulus(5'd5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        check_output("ares.run", 3'd3, 1'b0, 1'b1, 1'b0, 5'd0);
        apply_stimulus(5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        check_output("ares.noack", 3'd0, 1'b0, 1'b0, 1'b0, 5'd0);

        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end

endmodule
